// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the byte-serial memory arbiter: controller state
//   encoding, d_size codes, the IO-region address predicate and the helper
//   that turns a d_size code into a byte count.
package mem_arbiter_pkg;

  // Controller states: one idle state plus one state per kind of access.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DLOAD  = 2'd2,
    ST_DSTORE = 2'd3
  } arb_state_e;

  // d_size codes; the reserved code behaves like a word access.
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Address bits [17:16] equal to this value select the IO (UART) region.
  localparam logic [1:0] IO_REGION = 2'b11;

  // True when the upper address bits [17:16] select the IO region.
  function automatic logic isIoAddr(input logic [1:0] addrHi);
    return addrHi == IO_REGION;
  endfunction

  // Number of bytes moved by a data access of the given size code.
  function automatic logic [2:0] sizeToLen(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Byte-serial memory controller between the caches and the 8-bit RAM/IO
//   bus. Serves an instruction-block fetch channel and a data load/store
//   channel with fixed priority (data first). Fetches can be flushed; stores
//   into the IO region wait while the UART buffer is full.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   rdy                 global ready; low freezes every register
//   if_req/if_addr      instruction block request and aligned base address
//   if_flush            abort a fetch in progress or about to start
//   if_done/if_block    one-cycle completion pulse and the fetched block
//   d_req/d_we/d_size   data request, store select and access size
//   d_addr/d_wdata      data address and little-endian store data
//   d_done/d_rdata      one-cycle completion pulse and zero-extended load data
//   mem_din             read byte, valid one cycle after its address
//   mem_dout/mem_a      write byte and byte address
//   mem_wr              write strobe
//   io_buffer_full      UART buffer full; stalls IO-region stores
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  input  logic                     if_flush,
  output logic                     if_done,
  output logic [8*BLOCK_BYTES-1:0] if_block,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [1:0]               d_size,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_done,
  output logic [31:0]              d_rdata,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  // The counter must be able to reach BLOCK_BYTES itself, not just index it.
  localparam int CW = $clog2(BLOCK_BYTES) + 1;
  localparam int BW = 8 * BLOCK_BYTES;

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [BW-1:0]     fetchBuf_q, fetchBuf_d;
  logic [31:0]       loadBuf_q, loadBuf_d;
  logic              ifDone_q, ifDone_d;
  logic              dDone_q, dDone_d;
  logic [BW-1:0]     ifBlock_q, ifBlock_d;
  logic [31:0]       dRdata_q, dRdata_d;

  logic [CW-1:0]     laneSel;
  logic              byteValid;
  logic              ioStall;
  logic [BW-1:0]     fetchMerged;
  logic [31:0]       loadMerged;
  logic [31:0]       wdataShifted;

  // mem_din always carries the byte addressed in the previous cycle, so the
  // lane being filled is one behind the counter; nothing is valid at k == 0.
  assign laneSel   = cnt_q - CW'(1);
  assign byteValid = (cnt_q != '0);

  // IO stores hold in place while the UART cannot accept another byte.
  assign ioStall = (state_q == ST_DSTORE) && isIoAddr(base_q[17:16]) && io_buffer_full;

  // Fetch buffer with the incoming byte dropped into its lane. Bytes are
  // collected privately so a flushed fetch never disturbs if_block.
  for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_fetchLane
    assign fetchMerged[8*g +: 8] = (byteValid && laneSel == CW'(g)) ? mem_din
                                                                    : fetchBuf_q[8*g +: 8];
  end

  // Same lane merge for the 4-byte load buffer; unused upper lanes stay zero
  // because the buffer is cleared when a load starts.
  for (genvar g = 0; g < 4; g++) begin : g_loadLane
    assign loadMerged[8*g +: 8] = (byteValid && laneSel == CW'(g)) ? mem_din
                                                                   : loadBuf_q[8*g +: 8];
  end

  // Bus drive: the address and write byte follow the counter directly, so
  // they freeze together with the registers when rdy is low. Reads stop
  // driving the address once every byte has been requested.
  assign wdataShifted = wdata_q >> {cnt_q[1:0], 3'b000};

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_q)
      ST_IFETCH, ST_DLOAD: begin
        if (cnt_q < len_q) begin
          mem_a = base_q + ADDR_W'(cnt_q);
        end
      end
      ST_DSTORE: begin
        mem_a    = base_q + ADDR_W'(cnt_q);
        mem_dout = wdataShifted[7:0];
        mem_wr   = !ioStall;
      end
      default: ;
    endcase
  end

  // Next-state logic. Arbitration in IDLE gives data priority and ignores a
  // channel whose done pulse is showing this cycle, since its requester has
  // not yet had a chance to drop the request. A fetch in progress is never
  // preempted; only a flush ends it early.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    fetchBuf_d = fetchBuf_q;
    loadBuf_d  = loadBuf_q;
    ifDone_d   = 1'b0;
    dDone_d    = 1'b0;
    ifBlock_d  = ifBlock_q;
    dRdata_d   = dRdata_q;

    case (state_q)
      ST_IDLE: begin
        if (d_req && !dDone_q) begin
          state_d   = d_we ? ST_DSTORE : ST_DLOAD;
          base_d    = d_addr;
          len_d     = CW'(sizeToLen(d_size));
          wdata_d   = d_wdata;
          loadBuf_d = '0;
          cnt_d     = '0;
        end else if (if_req && !if_flush && !ifDone_q) begin
          state_d    = ST_IFETCH;
          base_d     = if_addr;
          len_d      = CW'(BLOCK_BYTES);
          fetchBuf_d = '0;
          cnt_d      = '0;
        end
      end

      ST_IFETCH: begin
        if (if_flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          fetchBuf_d = fetchMerged;
          if (cnt_q == len_q) begin
            ifBlock_d = fetchMerged;
            ifDone_d  = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_DLOAD: begin
        loadBuf_d = loadMerged;
        if (cnt_q == len_q) begin
          dRdata_d = loadMerged;
          dDone_d  = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DSTORE: begin
        if (!ioStall) begin
          if (cnt_q == len_q - CW'(1)) begin
            dDone_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. Reset wins over rdy and abandons whatever access was in
  // flight, including a partly written store; rdy low holds everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      fetchBuf_q <= '0;
      loadBuf_q  <= '0;
      ifDone_q   <= 1'b0;
      dDone_q    <= 1'b0;
      ifBlock_q  <= '0;
      dRdata_q   <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      fetchBuf_q <= fetchBuf_d;
      loadBuf_q  <= loadBuf_d;
      ifDone_q   <= ifDone_d;
      dDone_q    <= dDone_d;
      ifBlock_q  <= ifBlock_d;
      dRdata_q   <= dRdata_d;
    end
  end

  assign if_done  = ifDone_q;
  assign d_done   = dDone_q;
  assign if_block = ifBlock_q;
  assign d_rdata  = dRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed and randomized checks of mem_arbiter against a byte-array
//   reference memory. Latencies are derived from the access length.
module tb_mem_arbiter;

  localparam int BB = 16;
  localparam int AW = 32;
  localparam int BW = 8 * BB;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic          if_req, if_flush, if_done;
  logic [AW-1:0] if_addr;
  logic [BW-1:0] if_block;
  logic          d_req, d_we, d_done;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr, io_buffer_full;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram    [0:65535];
  logic [7:0]  refRam [0:65535];
  logic [39:0] wlog[$];
  logic [BW-1:0] oldBlock;

  mem_arbiter #(.BLOCK_BYTES(BB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_block(if_block),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one cycle read latency, frozen along with the system
  // when rdy is low. Every write is logged for comparison.
  always @(posedge clk) begin
    if (rdy === 1'b1) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr === 1'b1) begin
        ram[mem_a[15:0]] <= mem_dout;
        wlog.push_back({mem_a, mem_dout});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                             input logic [BW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int sizeLen(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refRam[16'(a + 32'(i))];
    return v;
  endfunction

  function automatic logic [BW-1:0] refBlock(input logic [31:0] a);
    logic [BW-1:0] v;
    for (int i = 0; i < BB; i++) v[8*i +: 8] = refRam[16'(a + 32'(i))];
    return v;
  endfunction

  task automatic setByte(input logic [31:0] a, input logic [7:0] v);
    ram[a[15:0]]    = v;
    refRam[a[15:0]] = v;
  endtask

  task automatic waitDone(input bit dataCh, input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(dataCh ? d_done : if_done) && cycles < limit);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ifdone"}, BW'(if_done), '0);
    checkOutput({tag, "_ddone"},  BW'(d_done),  '0);
    checkOutput({tag, "_block"},  if_block,     '0);
    checkOutput({tag, "_rdata"},  BW'(d_rdata), '0);
    checkOutput({tag, "_wr"},     BW'(mem_wr),  '0);
    checkOutput({tag, "_a"},      BW'(mem_a),   '0);
    checkOutput({tag, "_dout"},   BW'(mem_dout),'0);
  endtask

  task automatic applyStimulus(input bit dataCh, input bit we, input logic [31:0] a,
                               input logic [1:0] sz, input logic [31:0] w);
    if (dataCh) begin
      d_addr = a; d_size = sz; d_wdata = w; d_we = we; d_req = 1'b1;
    end else begin
      if_addr = a; if_req = 1'b1;
    end
  endtask

  task automatic doFetch(input string tag, input logic [31:0] a);
    int cyc;
    applyStimulus(1'b0, 1'b0, a, 2'b00, 32'h0);
    waitDone(1'b0, BB + 30, cyc);
    checkOutput({tag, "_lat"},   BW'(cyc), BW'(BB + 2));
    checkOutput({tag, "_block"}, if_block, refBlock(a));
    checkOutput({tag, "_excl"},  BW'(d_done), '0);
    if_req = 1'b0;
    tick();
  endtask

  task automatic doLoad(input string tag, input logic [31:0] a, input logic [1:0] sz);
    int cyc, n;
    n = sizeLen(sz);
    applyStimulus(1'b1, 1'b0, a, sz, 32'h0);
    waitDone(1'b1, n + 30, cyc);
    checkOutput({tag, "_lat"},   BW'(cyc), BW'(n + 2));
    checkOutput({tag, "_rdata"}, BW'(d_rdata), BW'(refLoad(a, n)));
    checkOutput({tag, "_excl"},  BW'(if_done), '0);
    d_req = 1'b0;
    tick();
  endtask

  task automatic doStore(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] w, input int stall);
    int cyc, n, extra;
    bit io;
    n     = sizeLen(sz);
    io    = (a[17:16] == 2'b11);
    extra = io ? stall : 0;
    wlog.delete();
    io_buffer_full = (stall > 0);
    applyStimulus(1'b1, 1'b1, a, sz, w);
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc > stall) io_buffer_full = 1'b0;
      if (io && cyc <= stall) checkOutput({tag, "_hold"}, BW'(mem_wr), '0);
    end while (!d_done && cyc < n + extra + 30);
    checkOutput({tag, "_lat"},  BW'(cyc), BW'(n + 1 + extra));
    checkOutput({tag, "_nwr"},  BW'(wlog.size()), BW'(n));
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      checkOutput({tag, "_wr"}, BW'(wlog[i]), BW'({a + 32'(i), w[8*i +: 8]}));
    end
    for (int i = 0; i < n; i++) refRam[16'(a + 32'(i))] = w[8*i +: 8];
    io_buffer_full = 1'b0;
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  initial begin
    int cyc, op, stall, seen;
    logic [31:0] a, w;
    logic [1:0]  sz;

    rst = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    io_buffer_full = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'($urandom);
      refRam[i] = ram[i];
    end

    // Reset state
    tick(); tick();
    checkReset("rst0");
    rst = 1'b1;
    tick();

    // Block fetch of bytes 0..15
    for (int k = 0; k < BB; k++) setByte(32'h100 + 32'(k), 8'(k));
    doFetch("fetch0", 32'h100);
    checkOutput("fetch0_const", if_block, 128'h0F0E0D0C0B0A09080706050403020100);

    // Simultaneous requests: data wins, fetch follows after the idle cycle
    setByte(32'h200, 8'h78); setByte(32'h201, 8'h56);
    setByte(32'h202, 8'h34); setByte(32'h203, 8'h12);
    applyStimulus(1'b0, 1'b0, 32'h100, 2'b00, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h200, 2'b10, 32'h0);
    waitDone(1'b1, 40, cyc);
    checkOutput("both_dlat",   BW'(cyc), BW'(6));
    checkOutput("both_rdata",  BW'(d_rdata), BW'(32'h12345678));
    checkOutput("both_noif",   BW'(if_done), '0);
    d_req = 1'b0;
    waitDone(1'b0, 50, cyc);
    checkOutput("both_iflat",  BW'(cyc), BW'(BB + 2));
    checkOutput("both_block",  if_block, 128'h0F0E0D0C0B0A09080706050403020100);
    if_req = 1'b0;
    tick();

    // Half store across a byte boundary, then a stalled IO byte store
    doStore("st_half", 32'h2001, 2'b01, 32'h0000ABCD, 0);
    doLoad("ld_half", 32'h2001, 2'b01);
    doStore("st_io", 32'h30000, 2'b00, 32'h00000041, 3);

    // Flush at k=5: no done, block untouched, refetch works
    oldBlock = if_block;
    applyStimulus(1'b0, 1'b0, 32'h300, 2'b00, 32'h0);
    for (int c = 0; c < 6; c++) tick();
    checkOutput("flush_k5", BW'(mem_a), BW'(32'h305));
    if_flush = 1'b1;
    tick();
    checkOutput("flush_idle", BW'(mem_a), '0);
    if_flush = 1'b0; if_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if_done) seen++;
    end
    checkOutput("flush_nodone", BW'(seen), '0);
    checkOutput("flush_block",  if_block, oldBlock);
    doFetch("refetch", 32'h300);

    // rdy low for 4 cycles in the middle of a word load
    for (int k = 0; k < 4; k++) setByte(32'h400 + 32'(k), 8'($urandom));
    applyStimulus(1'b1, 1'b0, 32'h400, 2'b10, 32'h0);
    cyc = 0;
    do begin
      tick();
      cyc++;
      rdy = !(cyc >= 2 && cyc < 6);
      if (cyc == 5) checkOutput("rdy_frozen_a", BW'(mem_a), BW'(32'h401));
    end while (!d_done && cyc < 40);
    checkOutput("rdy_lat",   BW'(cyc), BW'(10));
    checkOutput("rdy_rdata", BW'(d_rdata), BW'(refLoad(32'h400, 4)));
    d_req = 1'b0;
    tick();

    // Reset in the middle of a fetch
    applyStimulus(1'b0, 1'b0, 32'h500, 2'b00, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b0; if_req = 1'b0;
    tick();
    checkReset("rst1");
    rst = 1'b1;
    tick();
    doLoad("post_rst", 32'h400, 2'b10);

    // Randomized traffic against the reference memory
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 2));
      a  = $urandom;
      w  = $urandom;
      sz = 2'($urandom);
      if (op == 0) begin
        doFetch("rnd_fetch", a & ~32'(BB - 1));
      end else if (op == 1) begin
        doLoad("rnd_load", a, sz);
      end else begin
        stall = int'($urandom_range(0, 3));
        doStore("rnd_store", a, sz, w, stall);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
